// File: rtl/ef_i2s_pkg.sv
// ---------------------------------------------------------------------------
// ef_i2s_pkg
// Shared definitions for the EF_I2S capture path.
//  - state_t    : capture controller states (2-bit encoding)
//  - FIFO_LVL_W : width of the EF_I2S RX FIFO level field (depth 16)
// ---------------------------------------------------------------------------
package ef_i2s_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    FLUSH_PRE  = 2'd1,
    RUN        = 2'd2,
    FLUSH_POST = 2'd3
  } state_t;

  localparam int FIFO_LVL_W = 5;

endpackage

// File: rtl/i2s_ostage.sv
// ---------------------------------------------------------------------------
// i2s_ostage
// One-entry stream holding register between the RX FIFO head and the sink.
// Ports:
//  i_clk, i_rst  clock / asynchronous active-high reset
//  i_load        capture i_data and mark the entry valid
//  i_data        word to capture
//  i_accept      sink handshake (valid & ready) this cycle
//  i_flush       drop the entry without a handshake
//  o_valid       entry holds a word
//  o_data        held word (stable until accepted, flushed or reloaded)
// ---------------------------------------------------------------------------
module i2s_ostage #(
  parameter int DW = 32
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_load,
  input  logic [DW-1:0] i_data,
  input  logic          i_accept,
  input  logic          i_flush,
  output logic          o_valid,
  output logic [DW-1:0] o_data
);

  logic          r_valid;
  logic [DW-1:0] r_data;

  // Flush has priority; a load in the same cycle as an accept replaces the
  // outgoing word, which is what gives one word per cycle back-to-back.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (i_accept) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/i2s_capture_ctrl.sv
// ---------------------------------------------------------------------------
// i2s_capture_ctrl
// Runs one bounded capture session on an EF_I2S receiver: flush stale FIFO
// words, enable the receiver, drain the RX FIFO into a valid/ready stream,
// then flush again and pulse done.
// Ports:
//  i_clk, i_rst          clock / asynchronous active-high reset
//  i_start, i_abort      session control pulses
//  i_sample_count        words to deliver (0 = run until abort), taken on start
//  o_i2s_en              receiver enable (high only while running)
//  o_fifo_rd             RX FIFO pop strobe
//  i_fifo_empty/full     RX FIFO status
//  i_fifo_rdata          RX FIFO head word (no read latency)
//  o_m_valid/data/last   stream output, i_m_ready from the sink
//  o_busy, o_done        session active / one-cycle completion pulse
//  o_overflow, o_aborted sticky session status, cleared on start
//  o_delivered           words accepted by the sink this session
// ---------------------------------------------------------------------------
module i2s_capture_ctrl
  import ef_i2s_pkg::*;
#(
  parameter int DW       = 32,
  parameter int CNT_W    = 16,
  parameter bit OVF_STOP = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [CNT_W-1:0] i_sample_count,
  output logic             o_i2s_en,
  output logic             o_fifo_rd,
  input  logic             i_fifo_empty,
  input  logic             i_fifo_full,
  input  logic [DW-1:0]    i_fifo_rdata,
  output logic             o_m_valid,
  output logic [DW-1:0]    o_m_data,
  output logic             o_m_last,
  input  logic             i_m_ready,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_overflow,
  output logic             o_aborted,
  output logic [CNT_W-1:0] o_delivered
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state, w_next_state;
  logic [CNT_W-1:0] r_count, r_delivered;
  logic             r_overflow, r_aborted, r_done;

  logic             w_m_valid;
  logic [DW-1:0]    w_m_data;
  logic             w_accept, w_last_beat, w_last_hs, w_fetch_ok, w_stop;
  logic             w_i2s_en, w_fifo_rd, w_load, w_flush_buf, w_done_set;
  logic [CNT_W:0]   w_fetched;

  assign w_accept    = w_m_valid & i_m_ready;
  assign w_last_beat = w_m_valid & (r_count != '0) & (r_delivered == r_count - CNT_ONE);
  assign w_last_hs   = w_last_beat & i_m_ready;

  // Words already taken from the FIFO this session: delivered plus the one
  // sitting in the output buffer. Fetching stops once that reaches the
  // requested count, so the sink can never see an extra word.
  assign w_fetched  = {1'b0, r_delivered} + {{CNT_W{1'b0}}, w_m_valid};
  assign w_fetch_ok = (r_count == '0) || (w_fetched < {1'b0, r_count});

  assign w_stop = i_abort | (OVF_STOP & i_fifo_full);

  // Next-state and per-state strobes. A final handshake that coincides with
  // an abort/overflow still ends the session cleanly (not as an abort).
  always_comb begin
    w_next_state = r_state;
    w_i2s_en     = 1'b0;
    w_fifo_rd    = 1'b0;
    w_load       = 1'b0;
    w_flush_buf  = 1'b0;
    w_done_set   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (i_start) w_next_state = FLUSH_PRE;
      end
      FLUSH_PRE: begin
        w_fifo_rd = !i_fifo_empty;
        if (i_abort)           w_next_state = FLUSH_POST;
        else if (i_fifo_empty) w_next_state = RUN;
      end
      RUN: begin
        w_i2s_en = 1'b1;
        if (w_last_hs || w_stop) begin
          w_next_state = FLUSH_POST;
          w_flush_buf  = 1'b1;
        end else if (!i_fifo_empty && (!w_m_valid || i_m_ready) && w_fetch_ok) begin
          w_load    = 1'b1;
          w_fifo_rd = 1'b1;
        end
      end
      FLUSH_POST: begin
        w_fifo_rd = !i_fifo_empty;
        if (i_fifo_empty) begin
          w_next_state = IDLE;
          w_done_set   = 1'b1;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // State register, session counter and sticky status flags.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_count     <= '0;
      r_delivered <= '0;
      r_overflow  <= 1'b0;
      r_aborted   <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_done  <= w_done_set;
      if (r_state == IDLE && i_start) begin
        r_count     <= i_sample_count;
        r_delivered <= '0;
        r_overflow  <= 1'b0;
        r_aborted   <= 1'b0;
      end else begin
        if (r_state == RUN && w_accept)                r_delivered <= r_delivered + CNT_ONE;
        if (r_state == RUN && i_fifo_full)             r_overflow  <= 1'b1;
        if (r_state == RUN && w_stop && !w_last_hs)    r_aborted   <= 1'b1;
        if (r_state != IDLE && r_state != RUN && i_abort) r_aborted <= 1'b1;
      end
    end
  end

  i2s_ostage #(.DW(DW)) u_ostage (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_load   (w_load),
    .i_data   (i_fifo_rdata),
    .i_accept (w_accept),
    .i_flush  (w_flush_buf),
    .o_valid  (w_m_valid),
    .o_data   (w_m_data)
  );

  assign o_i2s_en    = w_i2s_en;
  assign o_fifo_rd   = w_fifo_rd;
  assign o_m_valid   = w_m_valid;
  assign o_m_data    = w_m_data;
  assign o_m_last    = w_last_beat;
  assign o_busy      = (r_state != IDLE);
  assign o_done      = r_done;
  assign o_overflow  = r_overflow;
  assign o_aborted   = r_aborted;
  assign o_delivered = r_delivered;

endmodule

// File: tb/tb_i2s_capture_ctrl.sv
// ---------------------------------------------------------------------------
// tb_i2s_capture_ctrl
// Directed bench for i2s_capture_ctrl with a behavioural 16-deep RX FIFO.
// Inputs change 1 time unit after the rising edge; outputs are observed on
// the falling edge.
// ---------------------------------------------------------------------------
module tb_i2s_capture_ctrl;
  import ef_i2s_pkg::*;

  localparam int FIFO_DEPTH = 1 << (FIFO_LVL_W - 1);

  logic        clk, rst, start, abort, mReady;
  logic [15:0] sampleCount;
  logic        i2sEn, fifoRd, fifoEmpty, fifoFull;
  logic [31:0] fifoRdata, mData;
  logic        mValid, mLast, busy, done, overflow, aborted;
  logic [15:0] delivered;

  int checks = 0;
  int passes = 0;

  // Behavioural RX FIFO (has its own clear, independent of the DUT reset)
  logic [31:0]           fifoMem [FIFO_DEPTH];
  logic [FIFO_LVL_W-2:0] fifoWp, fifoRp;
  logic [FIFO_LVL_W-1:0] fifoCnt;
  logic                  pushReq, fifoClr;
  logic [31:0]           pushData;
  logic                  fifoPush, fifoPop;

  assign fifoEmpty = (fifoCnt == 0);
  assign fifoFull  = (fifoCnt == FIFO_DEPTH);
  assign fifoRdata = fifoMem[fifoRp];
  assign fifoPush  = pushReq && !fifoFull;
  assign fifoPop   = fifoRd && !fifoEmpty;

  always @(posedge clk) begin
    if (fifoClr) begin
      fifoWp  <= '0;
      fifoRp  <= '0;
      fifoCnt <= '0;
    end else begin
      if (fifoPush) begin
        fifoMem[fifoWp] <= pushData;
        fifoWp          <= fifoWp + 1'b1;
      end
      if (fifoPop) fifoRp <= fifoRp + 1'b1;
      if (fifoPush && !fifoPop)      fifoCnt <= fifoCnt + 1'b1;
      else if (!fifoPush && fifoPop) fifoCnt <= fifoCnt - 1'b1;
    end
  end

  i2s_capture_ctrl #(.DW(32), .CNT_W(16), .OVF_STOP(1'b1)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_start        (start),
    .i_abort        (abort),
    .i_sample_count (sampleCount),
    .o_i2s_en       (i2sEn),
    .o_fifo_rd      (fifoRd),
    .i_fifo_empty   (fifoEmpty),
    .i_fifo_full    (fifoFull),
    .i_fifo_rdata   (fifoRdata),
    .o_m_valid      (mValid),
    .o_m_data       (mData),
    .o_m_last       (mLast),
    .i_m_ready      (mReady),
    .o_busy         (busy),
    .o_done         (done),
    .o_overflow     (overflow),
    .o_aborted      (aborted),
    .o_delivered    (delivered)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic driveEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic sampleMid();
    @(negedge clk);
  endtask

  // Pulse start and wait for the receiver enable; counts pre-flush pops.
  task automatic startSession(input logic [15:0] cnt, output bit ok, output int pops);
    ok   = 1'b0;
    pops = 0;
    driveEdge(); start = 1'b1; sampleCount = cnt;
    driveEdge(); start = 1'b0; sampleCount = 16'hFFFF;
    for (int c = 0; c < 30; c++) begin
      sampleMid();
      if (i2sEn) begin ok = 1'b1; break; end
      if (fifoRd) pops++;
      driveEdge();
    end
  endtask

  task automatic waitDone(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 40; c++) begin
      driveEdge(); pushReq = 1'b0;
      sampleMid();
      if (done) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; fifoClr = 1'b1; start = 1'b0; abort = 1'b0; mReady = 1'b0;
    sampleCount = '0; pushReq = 1'b0; pushData = '0;
    repeat (3) @(posedge clk);
    sampleMid();
    checks++;
    if ({i2sEn, fifoRd, mValid, mLast, busy, done, overflow, aborted} !== 8'b0)
      $display("[TB] FAIL reset_flags: got %b, expected 00000000",
               {i2sEn, fifoRd, mValid, mLast, busy, done, overflow, aborted});
    else passes++;
    checks++;
    if ({delivered, mData} !== 48'h0) $display("[TB] FAIL reset_data: got %h, expected 0", {delivered, mData});
    else passes++;
    driveEdge(); rst = 1'b0; fifoClr = 1'b0;
    sampleMid();
    checks++;
    if (busy !== 1'b0) $display("[TB] FAIL reset_idle_busy: got %b, expected 0", busy);
    else passes++;
  endtask

  task automatic test_preflush_counted();
    logic [31:0] words [6];
    bit ok, sawDone, prevPostEmpty;
    int pops, beats, runPops, pushIdx;
    for (int i = 0; i < 6; i++) words[i] = 32'hA500_0000 + i;
    mReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      driveEdge(); pushReq = 1'b1; pushData = 32'hDEAD_0000 + i;
    end
    driveEdge(); pushReq = 1'b0;
    startSession(16'd4, ok, pops);
    checks++;
    if (!ok) $display("[TB] FAIL t1_enter_run: got timeout, expected i2s_en");
    else passes++;
    checks++;
    if (pops !== 3) $display("[TB] FAIL t1_preflush_pops: got %0d, expected 3", pops);
    else passes++;
    beats = 0; runPops = 0; pushIdx = 0; sawDone = 1'b0; prevPostEmpty = 1'b0;
    for (int c = 0; c < 40; c++) begin
      driveEdge();
      pushReq = (pushIdx < 6);
      if (pushIdx < 6) begin pushData = words[pushIdx]; pushIdx++; end
      sampleMid();
      if (i2sEn && fifoRd) runPops++;
      if (mValid && mReady) begin
        checks++;
        if (beats > 5 || mData !== words[beats])
          $display("[TB] FAIL t1_data[%0d]: got %h, expected %h", beats, mData, words[beats % 6]);
        else passes++;
        checks++;
        if (mLast !== (beats == 3)) $display("[TB] FAIL t1_last[%0d]: got %b, expected %b", beats, mLast, beats == 3);
        else passes++;
        beats++;
      end
      if (done) begin
        sawDone = 1'b1;
        checks++;
        if ({prevPostEmpty, busy} !== 2'b10)
          $display("[TB] FAIL t1_done_timing: got post_empty,busy=%b, expected 10", {prevPostEmpty, busy});
        else passes++;
        break;
      end
      prevPostEmpty = busy && !i2sEn && fifoEmpty;
    end
    checks++;
    if (!sawDone || beats !== 4 || runPops !== 4)
      $display("[TB] FAIL t1_counts: got done=%b beats=%0d pops=%0d, expected 1/4/4", sawDone, beats, runPops);
    else passes++;
    checks++;
    if ({delivered, aborted, overflow, fifoCnt} !== {16'd4, 2'b00, 5'd0})
      $display("[TB] FAIL t1_status: got del=%0d ab=%b ov=%b lvl=%0d, expected 4/0/0/0", delivered, aborted, overflow, fifoCnt);
    else passes++;
    driveEdge(); sampleMid();
    checks++;
    if (done !== 1'b0) $display("[TB] FAIL t1_done_width: got %b, expected 0", done);
    else passes++;
  endtask

  task automatic test_back_to_back();
    bit ok;
    int pops, beats, runPops, pushIdx, firstCyc, lastCyc;
    mReady = 1'b1;
    startSession(16'd8, ok, pops);
    checks++;
    if (!ok) $display("[TB] FAIL t2_enter_run: got timeout, expected i2s_en");
    else passes++;
    beats = 0; runPops = 0; pushIdx = 0; firstCyc = -1; lastCyc = -1;
    for (int c = 0; c < 40; c++) begin
      driveEdge();
      pushReq = (pushIdx < 10); pushData = 32'hC0DE_0000 + pushIdx;
      if (pushIdx < 10) pushIdx++;
      sampleMid();
      if (i2sEn && fifoRd) runPops++;
      if (mValid && mReady) begin
        checks++;
        if (mData !== 32'hC0DE_0000 + beats) $display("[TB] FAIL t2_data[%0d]: got %h, expected %h", beats, mData, 32'hC0DE_0000 + beats);
        else passes++;
        if (firstCyc < 0) firstCyc = c;
        lastCyc = c;
        beats++;
      end
      if (done) break;
    end
    checks++;
    if (beats !== 8 || lastCyc - firstCyc !== 7)
      $display("[TB] FAIL t2_burst: got beats=%0d span=%0d, expected 8/7", beats, lastCyc - firstCyc);
    else passes++;
    checks++;
    if (runPops !== 8 || delivered !== 16'd8 || done !== 1'b1)
      $display("[TB] FAIL t2_no_ninth_read: got pops=%0d del=%0d done=%b, expected 8/8/1", runPops, delivered, done);
    else passes++;
  endtask

  task automatic test_stall();
    bit ok, prevStall;
    int pops, beats, lasts, pushIdx;
    logic [31:0] prevData;
    mReady = 1'b0;
    startSession(16'd5, ok, pops);
    checks++;
    if (!ok) $display("[TB] FAIL t3_enter_run: got timeout, expected i2s_en");
    else passes++;
    beats = 0; lasts = 0; pushIdx = 0; prevStall = 1'b0; prevData = '0;
    for (int c = 0; c < 60; c++) begin
      driveEdge();
      mReady  = c[0];
      pushReq = (pushIdx < 5); pushData = 32'h5EED_0000 + pushIdx;
      if (pushIdx < 5) pushIdx++;
      sampleMid();
      if (prevStall) begin
        checks++;
        if (!mValid || mData !== prevData)
          $display("[TB] FAIL t3_hold: got v=%b d=%h, expected v=1 d=%h", mValid, mData, prevData);
        else passes++;
      end
      if (mValid && mReady) begin
        checks++;
        if (mData !== 32'h5EED_0000 + beats) $display("[TB] FAIL t3_order[%0d]: got %h, expected %h", beats, mData, 32'h5EED_0000 + beats);
        else passes++;
        if (mLast) lasts++;
        beats++;
      end
      prevStall = mValid && !mReady;
      prevData  = mData;
      if (done) break;
    end
    mReady = 1'b1;
    checks++;
    if (beats !== 5 || lasts !== 1 || delivered !== 16'd5)
      $display("[TB] FAIL t3_summary: got beats=%0d lasts=%0d del=%0d, expected 5/1/5", beats, lasts, delivered);
    else passes++;
  endtask

  task automatic test_abort_continuous();
    bit ok, sawValid;
    int pops, beats, pushIdx;
    mReady = 1'b1;
    startSession(16'd0, ok, pops);
    checks++;
    if (!ok) $display("[TB] FAIL t4_enter_run: got timeout, expected i2s_en");
    else passes++;
    beats = 0; pushIdx = 0;
    for (int c = 0; c < 60 && beats < 20; c++) begin
      driveEdge();
      pushReq = (pushIdx < 20); pushData = 32'hE000_0000 + pushIdx;
      if (pushIdx < 20) pushIdx++;
      sampleMid();
      if (mValid && mReady) beats++;
    end
    driveEdge(); mReady = 1'b0; pushReq = 1'b1; pushData = 32'hE000_0020;
    sawValid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      driveEdge(); pushReq = 1'b0;
      sampleMid();
      if (mValid) begin sawValid = 1'b1; break; end
    end
    checks++;
    if (!sawValid || mData !== 32'hE000_0020 || mLast !== 1'b0 || delivered !== 16'd20)
      $display("[TB] FAIL t4_pending: got v=%b d=%h last=%b del=%0d, expected 1/e0000020/0/20", sawValid, mData, mLast, delivered);
    else passes++;
    driveEdge(); abort = 1'b1;
    driveEdge(); abort = 1'b0;
    sampleMid();
    checks++;
    if ({i2sEn, mValid, aborted, busy} !== 4'b0011 || delivered !== 16'd20)
      $display("[TB] FAIL t4_after_abort: got en,v,ab,busy=%b del=%0d, expected 0011/20", {i2sEn, mValid, aborted, busy}, delivered);
    else passes++;
    waitDone(ok);
    checks++;
    if (!ok || busy !== 1'b0 || aborted !== 1'b1 || delivered !== 16'd20)
      $display("[TB] FAIL t4_done: got done=%b busy=%b ab=%b del=%0d, expected 1/0/1/20", ok, busy, aborted, delivered);
    else passes++;
    mReady = 1'b1;
  endtask

  task automatic test_overflow_stop();
    bit ok, sawFull;
    int pops;
    mReady = 1'b0;
    startSession(16'd0, ok, pops);
    checks++;
    if (!ok) $display("[TB] FAIL t5_enter_run: got timeout, expected i2s_en");
    else passes++;
    sawFull = 1'b0;
    for (int c = 0; c < 40; c++) begin
      driveEdge();
      pushReq = (fifoCnt != FIFO_DEPTH); pushData = 32'h0F00_0000 + c;
      sampleMid();
      if (i2sEn && fifoFull) begin sawFull = 1'b1; break; end
    end
    driveEdge(); pushReq = 1'b0;
    sampleMid();
    checks++;
    if (!sawFull || {i2sEn, overflow, aborted, mValid} !== 4'b0110)
      $display("[TB] FAIL t5_ovf_stop: got full=%b en,ov,ab,v=%b, expected 1/0110", sawFull, {i2sEn, overflow, aborted, mValid});
    else passes++;
    waitDone(ok);
    checks++;
    if (!ok || fifoCnt !== 5'd0 || delivered !== 16'd0)
      $display("[TB] FAIL t5_flushed: got done=%b lvl=%0d del=%0d, expected 1/0/0", ok, fifoCnt, delivered);
    else passes++;
    mReady = 1'b1;
  endtask

  task automatic test_reset_midrun();
    bit ok;
    int pops, beats, pushIdx;
    mReady = 1'b1;
    startSession(16'd0, ok, pops);
    beats = 0; pushIdx = 0;
    for (int c = 0; c < 30 && beats < 3; c++) begin
      driveEdge();
      pushReq = (pushIdx < 3); pushData = 32'h6600_0000 + pushIdx;
      if (pushIdx < 3) pushIdx++;
      sampleMid();
      if (mValid && mReady) beats++;
    end
    @(posedge clk); #2;
    checks++;
    if (!ok || delivered !== 16'd3 || i2sEn !== 1'b1)
      $display("[TB] FAIL t6_pre_reset: got run=%b del=%0d en=%b, expected 1/3/1", ok, delivered, i2sEn);
    else passes++;
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({i2sEn, fifoRd, mValid, busy, done, overflow, aborted} !== 7'b0 || delivered !== 16'd0)
      $display("[TB] FAIL t6_async_reset: got flags=%b del=%0d, expected 0/0",
               {i2sEn, fifoRd, mValid, busy, done, overflow, aborted}, delivered);
    else passes++;
    driveEdge(); driveEdge(); rst = 1'b0;
    startSession(16'd2, ok, pops);
    checks++;
    if (!ok || delivered !== 16'd0) $display("[TB] FAIL t6_restart: got run=%b del=%0d, expected 1/0", ok, delivered);
    else passes++;
    beats = 0; pushIdx = 0;
    for (int c = 0; c < 30; c++) begin
      driveEdge();
      start = (c == 1); sampleCount = 16'd7;
      pushReq = (pushIdx < 4); pushData = 32'h7700_0000 + pushIdx;
      if (pushIdx < 4) pushIdx++;
      sampleMid();
      if (mValid && mReady) beats++;
      if (done) break;
    end
    start = 1'b0;
    checks++;
    if (beats !== 2 || delivered !== 16'd2 || done !== 1'b1)
      $display("[TB] FAIL t6_start_ignored: got beats=%0d del=%0d done=%b, expected 2/2/1", beats, delivered, done);
    else passes++;
  endtask

  task automatic test_start_abort_edges();
    bit ok, sawValid;
    mReady = 1'b0;
    driveEdge(); start = 1'b1; abort = 1'b1; sampleCount = 16'd1;
    driveEdge(); start = 1'b0; abort = 1'b0;
    sampleMid();
    checks++;
    if ({busy, aborted} !== 2'b10) $display("[TB] FAIL t7_start_wins: got busy,ab=%b, expected 10", {busy, aborted});
    else passes++;
    sawValid = 1'b0;
    for (int c = 0; c < 20; c++) begin
      driveEdge();
      pushReq = (c == 2); pushData = 32'h1234_5678;
      sampleMid();
      if (mValid) begin sawValid = 1'b1; break; end
    end
    checks++;
    if (!sawValid || mLast !== 1'b1 || mData !== 32'h1234_5678)
      $display("[TB] FAIL t7_single_last: got v=%b last=%b d=%h, expected 1/1/12345678", sawValid, mLast, mData);
    else passes++;
    driveEdge(); pushReq = 1'b0; mReady = 1'b1; abort = 1'b1;
    driveEdge(); mReady = 1'b0; abort = 1'b0;
    sampleMid();
    checks++;
    if (delivered !== 16'd1 || {aborted, i2sEn} !== 2'b00)
      $display("[TB] FAIL t7_abort_on_last: got del=%0d ab,en=%b, expected 1/00", delivered, {aborted, i2sEn});
    else passes++;
    waitDone(ok);
    checks++;
    if (!ok || aborted !== 1'b0) $display("[TB] FAIL t7_done: got done=%b ab=%b, expected 1/0", ok, aborted);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_preflush_counted();
    test_back_to_back();
    test_stall();
    test_abort_continuous();
    test_overflow_stop();
    test_reset_midrun();
    test_start_abort_edges();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
